// File: rtl/alu_pkg.sv
// Shared ALU definitions: selector codes, opcodes and the issued-beat bundle.
// Imported by the issue stage, its decoder and the ALU.
package alu_pkg;

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SLL  = 4'b0001;
  localparam logic [3:0] SEL_SLT  = 4'b0010;
  localparam logic [3:0] SEL_SLTU = 4'b0011;
  localparam logic [3:0] SEL_XOR  = 4'b0100;
  localparam logic [3:0] SEL_SRL  = 4'b0101;
  localparam logic [3:0] SEL_OR   = 4'b0110;
  localparam logic [3:0] SEL_AND  = 4'b0111;
  localparam logic [3:0] SEL_SUB  = 4'b1000;
  localparam logic [3:0] SEL_SRA  = 4'b1001;
  localparam logic [3:0] SEL_BEQ  = 4'b1010;
  localparam logic [3:0] SEL_BNE  = 4'b1011;
  localparam logic [3:0] SEL_BLT  = 4'b1100;
  localparam logic [3:0] SEL_BGE  = 4'b1101;
  localparam logic [3:0] SEL_BLTU = 4'b1110;
  localparam logic [3:0] SEL_BGEU = 4'b1111;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [3:0]  selector;
    logic [4:0]  rd;
    logic        is_branch;
    logic        illegal;
  } beat_t;

  function automatic beat_t beat_illegal();
    beat_t b;
    b         = '0;
    b.illegal = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I ALU decoder: instruction plus
// register data to an issued beat.
module alu_issue_dec
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output beat_t       beat_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;
  logic [31:0] shamt;
  logic        unused_rs1_idx;
  beat_t       b;
  logic        legal;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign imm   = {{20{instr_i[31]}}, instr_i[31:20]};
  assign shamt = {27'd0, instr_i[24:20]};
  assign unused_rs1_idx = ^instr_i[19:15];

  always_comb begin
    b       = '0;
    legal   = 1'b0;
    b.dataA = rs1_i;
    b.dataB = rs2_i;
    b.rd    = instr_i[11:7];
    unique case (1'b1)
      (opc == OP_R): begin
        if (f7 == F7_BASE) begin
          legal      = 1'b1;
          b.selector = {1'b0, f3};
        end else if (f7 == F7_ALT) begin
          legal      = (f3 == 3'b000) || (f3 == 3'b101);
          b.selector = (f3 == 3'b000) ? SEL_SUB : SEL_SRA;
        end
      end
      (opc == OP_I): begin
        legal      = 1'b1;
        b.dataB    = imm;
        b.selector = {1'b0, f3};
        if (f3 == 3'b001) begin
          b.dataB = shamt;
          legal   = (f7 == F7_BASE);
        end else if (f3 == 3'b101) begin
          b.dataB    = shamt;
          legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
          b.selector = (f7 == F7_ALT) ? SEL_SRA : SEL_SRL;
        end
      end
      (opc == OP_B): begin
        legal       = (f3[2:1] != 2'b01);
        b.rd        = 5'd0;
        b.is_branch = 1'b1;
        // 000/001 -> 101x, 1xx -> 1xxx
        b.selector  = f3[2] ? {1'b1, f3} : {3'b101, f3[0]};
      end
      default: legal = 1'b0;
    endcase
    beat_o = legal ? b : beat_illegal();
  end

endmodule

// File: rtl/alu_issue.sv
// ALU decode-and-issue stage: decoder, 2-entry registered
// skid buffer, issue counter and sticky illegal flag.
module alu_issue
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs1_data,
  input  logic [31:0]      in_rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_dataA,
  output logic [31:0]      out_dataB,
  output logic [3:0]       out_selector,
  output logic [4:0]       out_rd,
  output logic             out_is_branch,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issue_count,
  output logic             illegal_seen
);

  beat_t            dec;
  beat_t            m_q, m_d;
  beat_t            s_q, s_d;
  logic             m_vld_q, m_vld_d;
  logic             s_vld_q, s_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;
  logic             in_fire;
  logic             out_fire;

  alu_issue_dec u_dec (
    .instr_i (in_instr),
    .rs1_i   (in_rs1_data),
    .rs2_i   (in_rs2_data),
    .beat_o  (dec)
  );

  assign in_ready = !s_vld_q;
  assign in_fire  = in_valid && !s_vld_q;
  assign out_fire = m_vld_q && out_ready;

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    // in_fire implies S empty, so S->M never races a new beat
    if (out_fire && s_vld_q) begin
      m_d     = s_q;
      s_vld_d = 1'b0;
    end else if (in_fire && (!m_vld_q || out_fire)) begin
      m_d     = dec;
      m_vld_d = 1'b1;
    end else if (in_fire) begin
      s_d     = dec;
      s_vld_d = 1'b1;
    end else if (out_fire) begin
      m_vld_d = 1'b0;
    end
    if (out_fire) begin
      cnt_d = cnt_q + 1'b1;
      ill_d = ill_q || m_q.illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid     = m_vld_q;
  assign out_dataA     = m_q.dataA;
  assign out_dataB     = m_q.dataB;
  assign out_selector  = m_q.selector;
  assign out_rd        = m_q.rd;
  assign out_is_branch = m_q.is_branch;
  assign out_illegal   = m_q.illegal;
  assign issue_count   = cnt_q;
  assign illegal_seen  = ill_q;

endmodule
